serial_pwm_cmd_ctrl: RTL and testbench
======================================

# serial_pwm_cmd_ctrl

Command sequencer between the UART byte receiver/transmitter and the PWM motor stage of the Serial_PWM design. Parses framed commands arriving as received bytes, validates them by checksum and inter-byte timeout, and programs the PWM duty, direction and enable registers. It inserts a dead-time brake on direction reversal and returns status bytes through the transmitter handshake.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency (20 ns period).
- `TIMEOUT_CYC`, 500_000, maximum idle cycles between bytes of one frame (10 ms).
- `DEAD_CYC`, 1_000, cycles duty is forced to 0 on direction reversal.
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `tx_ready`  in  1  transmitter can accept a byte.
- `tx_valid`  out  1  `tx_data` holds a byte for the transmitter.
- `tx_data`  out  8  byte to transmit.
- `duty`  out  8  PWM duty, 0 = off, 255 = full.
- `DIR`  out  1  motor direction, 0 = forward.
- `pwm_en`  out  1  PWM output enable.
- `err_cnt`  out  8  saturating count of rejected frames and dropped bytes.

## Operation
- Frame: `0xAA`, CMD, ARG, SUM. SUM = (CMD + ARG) mod 256.
- Commands:
  - `0x01` set duty = ARG.
  - `0x02` set direction = ARG[0].
  - `0x03` stop: duty = 0, `pwm_en` = 0.
  - `0x04` start: `pwm_en` = 1.
  - `0x05` query status.
- FSM states:
  - IDLE: a byte `0xAA` → CMD. Any other byte is ignored and does not count as an error.
  - CMD → ARG → SUM: each state advances on `rx_valid`.
  - SUM: checksum match → EXEC. Mismatch → IDLE and `err_cnt`++.
  - EXEC: apply the command. Go to RESP if CMD = `0x05`, otherwise IDLE.
  - RESP: send status `{pwm_en, DIR, brake_active, 5'b0}`, then send `duty`. Then → IDLE.
- An unknown CMD with a valid checksum: `err_cnt`++, no register change.
- Timeout counter: runs in CMD/ARG/SUM and clears on each accepted byte. Reaching `TIMEOUT_CYC` → IDLE and `err_cnt`++.
- A byte arriving in EXEC or RESP is dropped and `err_cnt`++.
- `err_cnt` saturates at 255.
- Direction reversal (new DIR ≠ current DIR) while `duty` ≠ 0:
  - Brake: output duty forced to 0 for `DEAD_CYC` cycles.
  - DIR then switches and the stored duty is restored.
  - A new set-duty during the brake updates the stored duty only.
  - A stop during the brake cancels the brake and applies DIR immediately.
- Reversal with `duty` = 0 switches DIR immediately.

## Timing
- Reset values: `duty` 0, `DIR` 0, `pwm_en` 0, `tx_valid` 0, `tx_data` 0, `err_cnt` 0, FSM IDLE, brake inactive.
- Reset is asynchronous and may assert mid-frame or mid-brake; it aborts everything with no partial update.
- Latency: register outputs update on the 2nd rising edge after the edge that accepts SUM (edge 1 → EXEC, edge 2 → outputs).
- TX handshake:
  - `tx_valid` and `tx_data` are held stable until an edge with `tx_ready` = 1.
  - `tx_valid` deasserts, or presents the next byte, on that same edge.
  - The first status byte is valid the cycle after EXEC.
- Back-to-back frames with zero gap are accepted; the next `0xAA` may arrive in the cycle after IDLE is re-entered.

## Configuration
- `SERIAL_PWM_ACK_EN` defined: every executed non-query command sends one byte in RESP.
  - `0x06` (ACK) for a known command.
  - `0x15` (NAK) for an unknown command or checksum mismatch.
  - Timeouts send nothing.
- `SERIAL_PWM_ACK_EN` undefined: TX is used only by query; mismatches and unknown commands are silent.

## Structure
- Package `serial_pwm_pkg`:
  - FSM state enum.
  - Constants: `SYNC_BYTE` `0xAA`, command codes, `ACK` `0x06`, `NAK` `0x15`.
- Sub-module `dir_brake_seq`: owns the dead-time counter, stored duty and DIR switching. The main FSM issues set-duty, set-dir and stop strobes to it.

## Test plan
- Frame `AA 01 80 81` → `duty` = `0x80` two edges after SUM; `err_cnt` = 0.
- Frame `AA 01 80 00` → `duty` unchanged, `err_cnt` = 1, FSM back in IDLE.
- Send `AA 01`, then idle `TIMEOUT_CYC` cycles → FSM IDLE, `err_cnt` = 1. A following valid frame is executed.
- With `duty` = `0x80` and `DIR` = 0, frame `AA 02 01 03` → `duty` = 0 for exactly `DEAD_CYC` cycles, then `DIR` = 1 and `duty` = `0x80`.
- Frame `AA 05 00 05` with `tx_ready` held low 5 cycles → `tx_valid` held with a stable status byte. Then `tx_data` = status, followed by `tx_data` = `duty`.
- `RESET` asserted mid-brake → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/serial_pwm_pkg.sv
// serial_pwm_pkg: FSM states, protocol bytes and saturating add shared by the Serial_PWM command path
package serial_pwm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_SUM, S_EXEC, S_RESP} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [7:0] CMD_DUTY  = 8'h01;
  localparam logic [7:0] CMD_DIR   = 8'h02;
  localparam logic [7:0] CMD_STOP  = 8'h03;
  localparam logic [7:0] CMD_START = 8'h04;
  localparam logic [7:0] CMD_QUERY = 8'h05;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/dir_brake_seq.sv
// dir_brake_seq: stored duty, direction register and dead-time brake on direction reversal
module dir_brake_seq #(
  parameter int DEAD_CYC = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_duty,
  input  logic       set_dir,
  input  logic       stop,
  input  logic [7:0] arg,
  output logic [7:0] duty,
  output logic       dir,
  output logic       brake_active
);
  localparam int CW = $clog2(DEAD_CYC + 1);
  logic [7:0] held;
  logic [CW-1:0] cnt;
  logic pend, brk_end, cur_dir;
  assign brk_end = brake_active && cnt == CW'(DEAD_CYC - 1);
  assign cur_dir = brk_end ? pend : dir;
  assign duty = brake_active ? 8'h00 : held;
  // dead-time countdown, deferred direction switch and stored duty updates
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      held <= 8'h00;
      cnt <= '0;
      pend <= 1'b0;
      dir <= 1'b0;
      brake_active <= 1'b0;
    end else begin
      cnt <= (brake_active && !brk_end) ? cnt + 1'b1 : '0;
      if (brk_end) begin
        brake_active <= 1'b0;
        dir <= pend;
      end
      if (set_duty) held <= arg;
      if (stop) begin
        held <= 8'h00;
        brake_active <= 1'b0;
        dir <= brake_active ? pend : dir;
      end
      if (set_dir && brake_active && !brk_end) pend <= arg[0];
      else if (set_dir && arg[0] != cur_dir && held != 8'h00) begin
        brake_active <= 1'b1;
        pend <= arg[0];
      end else if (set_dir) dir <= arg[0];
    end
endmodule

// File: rtl/serial_pwm_cmd_ctrl.sv
// serial_pwm_cmd_ctrl: framed UART command parser programming PWM duty/dir/enable; SERIAL_PWM_ACK_EN adds ACK/NAK replies
module serial_pwm_cmd_ctrl
  import serial_pwm_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 100,
  parameter int DEAD_CYC    = 1_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [7:0] duty,
  output logic       DIR,
  output logic       pwm_en,
  output logic [7:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t st, nxt;
  logic [7:0] cmd, arg, tx_byte;
  logic [TW-1:0] tmo;
  logic [1:0] inc;
  logic second, two, tx_ld, tx_done, set_duty, set_dir, stop, start;
  logic brake_active, busy, tmo_hit, unknown;
  assign busy = st inside {S_CMD, S_ARG, S_SUM};
  assign tmo_hit = busy && !rx_valid && tmo == TW'(TIMEOUT_CYC - 1);
  assign unknown = cmd == 8'h00 || cmd > CMD_QUERY;
  // next state, command strobes, error increments and TX loads
  always_comb begin
    nxt = st;
    inc = 2'd0;
    {set_duty, set_dir, stop, start, tx_ld, tx_done, two} = '0;
    tx_byte = 8'h00;
    case (st)
      S_IDLE: nxt = (rx_valid && rx_data == SYNC_BYTE) ? S_CMD : S_IDLE;
      S_CMD, S_ARG: begin
        nxt = rx_valid ? (st == S_CMD ? S_ARG : S_SUM) : tmo_hit ? S_IDLE : st;
        inc = {1'b0, tmo_hit};
      end
      S_SUM: begin
        if (rx_valid && rx_data == cmd + arg) nxt = S_EXEC;
        else if (rx_valid) begin
          inc = 2'd1;
`ifdef SERIAL_PWM_ACK_EN
          nxt = S_RESP;
          tx_ld = 1'b1;
          tx_byte = NAK;
`else
          nxt = S_IDLE;
`endif
        end else if (tmo_hit) begin
          nxt = S_IDLE;
          inc = 2'd1;
        end
      end
      S_EXEC: begin
        inc = {1'b0, rx_valid} + {1'b0, unknown};
        set_duty = cmd == CMD_DUTY;
        set_dir = cmd == CMD_DIR;
        stop = cmd == CMD_STOP;
        start = cmd == CMD_START;
        two = cmd == CMD_QUERY;
`ifdef SERIAL_PWM_ACK_EN
        nxt = S_RESP;
        tx_ld = 1'b1;
        tx_byte = two ? {pwm_en, DIR, brake_active, 5'b0} : unknown ? NAK : ACK;
`else
        nxt = two ? S_RESP : S_IDLE;
        tx_ld = two;
        tx_byte = {pwm_en, DIR, brake_active, 5'b0};
`endif
      end
      S_RESP: begin
        inc = {1'b0, rx_valid};
        tx_ld = tx_ready && second;
        tx_done = tx_ready && !second;
        tx_byte = duty;
        nxt = tx_done ? S_IDLE : S_RESP;
      end
      default: nxt = S_IDLE;
    endcase
  end
  // FSM state register
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) st <= S_IDLE;
    else st <= nxt;
  // frame capture, inter-byte timeout, error counter and TX holding registers
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      cmd <= 8'h00;
      arg <= 8'h00;
      tmo <= '0;
      err_cnt <= 8'h00;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
      second <= 1'b0;
    end else begin
      if (rx_valid && st == S_CMD) cmd <= rx_data;
      if (rx_valid && st == S_ARG) arg <= rx_data;
      tmo <= (busy && !rx_valid && !tmo_hit) ? tmo + 1'b1 : '0;
      err_cnt <= sat_add(err_cnt, inc);
      if (tx_ld) begin
        tx_valid <= 1'b1;
        tx_data <= tx_byte;
        second <= two;
      end else if (tx_done) tx_valid <= 1'b0;
    end
  // PWM enable follows start/stop commands
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) pwm_en <= 1'b0;
    else if (start || stop) pwm_en <= start;
  dir_brake_seq #(.DEAD_CYC(DEAD_CYC)) u_brake (
    .clk(CLK),
    .rst(RESET),
    .set_duty(set_duty),
    .set_dir(set_dir),
    .stop(stop),
    .arg(arg),
    .duty(duty),
    .dir(DIR),
    .brake_active(brake_active)
  );
endmodule

// File: tb/tb_serial_pwm_cmd_ctrl.sv
// tb_serial_pwm_cmd_ctrl: randomized frames against a behavioural command model with a TX scoreboard
module tb_serial_pwm_cmd_ctrl;
  import serial_pwm_pkg::*;
  localparam int TMO = 100;
  localparam int DEAD = 40;
  logic CLK, RESET, rx_valid, tx_ready, tx_valid, DIR, pwm_en;
  logic [7:0] rx_data, tx_data, duty, err_cnt;
  int tests, fails;
  logic [7:0] exp_q[$];
  logic [7:0] m_duty, m_err;
  logic m_dir, m_en;
  bit hold_rdy, pend_hold;
  logic [7:0] hold_data;

  serial_pwm_cmd_ctrl #(.TIMEOUT_CYC(TMO), .DEAD_CYC(DEAD)) dut (
    .CLK(CLK), .RESET(RESET), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .duty(duty), .DIR(DIR), .pwm_en(pwm_en), .err_cnt(err_cnt)
  );

  initial begin
    CLK = 0;
    forever #10 CLK = ~CLK;
  end

  initial begin
    tx_ready = 0;
    forever begin
      @(posedge CLK);
      #1 tx_ready = hold_rdy ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted TX byte must match the oldest expected byte
  always @(negedge CLK) begin
    if (RESET) pend_hold = 0;
    else begin
      if (pend_hold) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(hold_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected: got 0x%0h expected no byte at %0t", tx_data, $time);
        end else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      pend_hold = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic bump();
    m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
  endtask

  // Behavioural command model: what a frame must do once fully settled
  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input bit ok);
    if (!ok) begin
      bump();
`ifdef SERIAL_PWM_ACK_EN
      exp_q.push_back(NAK);
`endif
      return;
    end
    case (c)
      8'h01: m_duty = a;
      8'h02: m_dir = a[0];
      8'h03: begin m_duty = 0; m_en = 0; end
      8'h04: m_en = 1;
      8'h05: begin exp_q.push_back({m_en, m_dir, 6'b0}); exp_q.push_back(m_duty); end
      default: bump();
    endcase
`ifdef SERIAL_PWM_ACK_EN
    if (c != 8'h05) exp_q.push_back((c >= 8'h01 && c <= 8'h04) ? ACK : NAK);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_valid = 1;
    rx_data = b;
  endtask

  task automatic rx_off();
    @(negedge CLK);
    rx_valid = 0;
  endtask

  task automatic send_g(input logic [7:0] b, input int gap);
    send_byte(b);
    if (gap > 0) begin
      rx_off();
      repeat (gap - 1) @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s, input int gap);
    model_frame(c, a, s == 8'(c + a));
    send_g(SYNC_BYTE, gap);
    send_g(c, gap);
    send_g(a, gap);
    send_byte(s);
    rx_off();
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge CLK);
    while (tx_valid && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("tx_drain", 32'(tx_valid), 32'd0);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_duty"}, 32'(duty), 32'(m_duty));
    chk({tag, "_dir"}, 32'(DIR), 32'(m_dir));
    chk({tag, "_en"}, 32'(pwm_en), 32'(m_en));
    chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s, input int gap);
    send_frame(c, a, s, gap);
    drain();
    if (c == CMD_DIR) repeat (DEAD + 3) @(negedge CLK);
    chk_regs("frame");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_duty"}, 32'(duty), 32'd0);
    chk({tag, "_dir"}, 32'(DIR), 32'd0);
    chk({tag, "_en"}, 32'(pwm_en), 32'd0);
    chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_txd"}, 32'(tx_data), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    int r, n;
    logic [7:0] c, a, s, b;
    RESET = 1;
    rx_valid = 0;
    rx_data = 0;
    m_duty = 0; m_err = 0; m_dir = 0; m_en = 0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    @(posedge CLK);
    #2 RESET = 0;
    // set duty with two-edge latency after SUM
    send_frame(8'h01, 8'h80, 8'h81, 0);
    chk("lat_edge1_duty", 32'(duty), 32'd0);
    @(negedge CLK);
    chk("lat_edge2_duty", 32'(duty), 32'h80);
    chk("lat_err", 32'(err_cnt), 32'd0);
    drain();
    chk_regs("set_duty");
    // checksum mismatch
    run_frame(8'h01, 8'h80, 8'h00, 0);
    chk("bad_sum_err", 32'(err_cnt), 32'd1);
    // inter-byte timeout, then a valid frame must still execute
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    rx_off();
    repeat (TMO + 5) @(negedge CLK);
    bump();
    chk_regs("timeout");
    run_frame(8'h01, 8'h40, 8'h41, 0);
    run_frame(8'h01, 8'h80, 8'h81, 0);
    run_frame(8'h04, 8'h00, 8'h04, 0);
    // direction reversal dead time
    send_frame(8'h02, 8'h01, 8'h03, 0);
    n = 0;
    @(negedge CLK);
    chk("brake_start_dir", 32'(DIR), 32'd0);
    while (duty == 8'h00 && n < DEAD + 20) begin
      n++;
      @(negedge CLK);
    end
    chk("brake_len", 32'(n), 32'(DEAD));
    chk("brake_end_dir", 32'(DIR), 32'd1);
    chk("brake_end_duty", 32'(duty), 32'h80);
    drain();
    chk_regs("brake");
    // query held off by tx_ready, with a byte dropped during RESP
    hold_rdy = 1;
    send_frame(8'h05, 8'h00, 8'h05, 0);
    repeat (5) begin
      @(negedge CLK);
      chk("query_hold_valid", 32'(tx_valid), 32'd1);
      chk("query_hold_status", 32'(tx_data), 32'hC0);
    end
    send_byte(8'h55);
    rx_off();
    bump();
    hold_rdy = 0;
    drain();
    chk_regs("query");
    // back-to-back frames
    send_frame(8'h01, 8'h20, 8'h21, 0);
`ifdef SERIAL_PWM_ACK_EN
    drain();
`endif
    send_frame(8'h01, 8'h30, 8'h31, 0);
    drain();
    chk_regs("b2b");
    // randomized frames, garbage, unknown commands and timeouts
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        send_byte(SYNC_BYTE);
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        rx_off();
        repeat (TMO + 5) @(negedge CLK);
        bump();
        chk_regs("rand_timeout");
      end else begin
        if (r == 1) begin
          b = 8'($urandom);
          if (b == SYNC_BYTE) b = 8'h55;
          send_byte(b);
          rx_off();
        end
        c = (r == 2) ? 8'h00 : (r == 3) ? 8'h9C : 8'($urandom_range(1, 5));
        a = 8'($urandom);
        s = ($urandom_range(0, 7) == 0) ? 8'(c + a + 8'd1) : 8'(c + a);
        run_frame(c, a, s, int'($urandom_range(0, 3)));
      end
    end
    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      a = 8'($urandom);
      run_frame(8'h01, a, 8'(a + 8'd2), 0);
    end
    chk("err_saturated", 32'(err_cnt), 32'hFF);
    // asynchronous reset in the middle of a brake
    run_frame(8'h01, 8'h90, 8'h91, 0);
    a = {7'b0, ~m_dir};
    send_frame(8'h02, a, 8'(8'h02 + a), 0);
    repeat (5) @(negedge CLK);
    chk("mid_brake_duty", 32'(duty), 32'd0);
    #3 RESET = 1;
    exp_q.delete();
    #1 chk_reset_vals("async_reset");
    repeat (2) @(posedge CLK);
    #2 RESET = 0;
    m_duty = 0; m_err = 0; m_dir = 0; m_en = 0;
    run_frame(8'h01, 8'h11, 8'h12, 0);
    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
